// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between loads and committed stores. Stores wait in an
// in-order FIFO; MMIO stores are sequenced against IO-busy with a guard cycle between them.
module mem_port_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IN_stValid,
    input  logic [31:0] IN_stAddr,
    input  logic [31:0] IN_stData,
    input  logic [3:0]  IN_stMask,
    output logic        OUT_stDisable,
    input  logic        IN_ldValid,
    input  logic [31:0] IN_ldAddr,
    output logic        OUT_ldGrant,
    input  logic        IN_IO_busy,
    output logic        OUT_memValid,
    output logic        OUT_memWe,
    output logic [31:0] OUT_memAddr,
    output logic [31:0] OUT_memData,
    output logic [3:0]  OUT_memMask,
    input  logic        IN_memReady,
    output logic        OUT_empty,
    output logic        OUT_overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] HIGH_WATER = CW'(FIFO_DEPTH - 1);
    localparam logic [SW-1:0] LIMIT_C    = SW'(STARVE_LIMIT);

    localparam logic [1:0] S_NORMAL  = 2'd0;
    localparam logic [1:0] S_IO_WAIT = 2'd1;
    localparam logic [1:0] S_GUARD   = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_ST   = 2'd1;
    localparam logic [1:0] OWN_LD   = 2'd2;

    logic [31:0]   addr_mem_q [FIFO_DEPTH];
    logic [31:0]   data_mem_q [FIFO_DEPTH];
    logic [3:0]    mask_mem_q [FIFO_DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    own_q, own_d;
    logic          overflow_q, overflow_d;

    logic [31:0] head_addr, head_data;
    logic [3:0]  head_mask;
    logic        has_head, head_io, st_elig;
    logic        st_gnt, ld_gnt, mem_valid, push, pop;

    assign head_addr = addr_mem_q[head_q];
    assign head_data = data_mem_q[head_q];
    assign head_mask = mask_mem_q[head_q];
    assign has_head  = (count_q != '0);
    assign head_io   = has_head && (head_addr[31:24] == 8'hFF);
    assign st_elig   = has_head && (!head_io || (state_q == S_NORMAL && !IN_IO_busy));

    // An owner that has not yet seen IN_memReady keeps the port regardless of arbitration.
    always_comb begin
        st_gnt = 1'b0;
        ld_gnt = 1'b0;
        if (own_q == OWN_ST) begin
            st_gnt = has_head;
        end else if (own_q == OWN_LD && IN_ldValid) begin
            ld_gnt = 1'b1;
        end else if (st_elig && (!IN_ldValid || count_q == DEPTH_C || starve_q >= LIMIT_C)) begin
            st_gnt = 1'b1;
        end else begin
            ld_gnt = IN_ldValid;
        end
    end

    assign mem_valid = st_gnt || ld_gnt;
    assign pop       = st_gnt && IN_memReady;
    assign push      = IN_stValid && (count_q != DEPTH_C || pop);

    always_comb begin
        head_d     = pop  ? head_q + PW'(1) : head_q;
        tail_d     = push ? tail_q + PW'(1) : tail_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q || (IN_stValid && count_q == DEPTH_C && !pop);
        own_d      = (mem_valid && !IN_memReady) ? (st_gnt ? OWN_ST : OWN_LD) : OWN_NONE;

        starve_d = starve_q;
        if (pop || !st_elig) begin
            starve_d = '0;
        end else if (ld_gnt && starve_q != LIMIT_C) begin
            starve_d = starve_q + SW'(1);
        end

        state_d = state_q;
        if (pop && head_io) begin
            state_d = S_GUARD;
        end else begin
            case (state_q)
                S_NORMAL:  if (head_io && IN_IO_busy && !st_gnt) state_d = S_IO_WAIT;
                S_IO_WAIT: if (!IN_IO_busy) state_d = S_NORMAL;
                default:   state_d = S_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[tail_q] <= IN_stAddr;
            data_mem_q[tail_q] <= IN_stData;
            mask_mem_q[tail_q] <= IN_stMask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            state_q    <= S_NORMAL;
            own_q      <= OWN_NONE;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            state_q    <= state_d;
            own_q      <= own_d;
            overflow_q <= overflow_d;
        end
    end

    assign OUT_stDisable = (count_q >= HIGH_WATER);
    assign OUT_empty     = (count_q == '0);
    assign OUT_overflow  = overflow_q;
    assign OUT_memValid  = mem_valid;
    assign OUT_memWe     = st_gnt;
    assign OUT_ldGrant   = ld_gnt && !st_gnt;
    assign OUT_memAddr   = st_gnt ? head_addr : IN_ldAddr;
    assign OUT_memData   = st_gnt ? head_data : 32'h0;
    assign OUT_memMask   = st_gnt ? head_mask : 4'hF;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed timing scenarios plus a random run,
// with a negedge monitor checking every port transfer against the expected store order.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        IN_stValid, IN_ldValid, IN_IO_busy, IN_memReady;
    logic [31:0] IN_stAddr, IN_stData, IN_ldAddr;
    logic [3:0]  IN_stMask;
    logic        OUT_stDisable, OUT_ldGrant, OUT_memValid, OUT_memWe, OUT_empty, OUT_overflow;
    logic [31:0] OUT_memAddr, OUT_memData;
    logic [3:0]  OUT_memMask;

    always #5 clk = ~clk;

    mem_port_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .IN_stValid(IN_stValid), .IN_stAddr(IN_stAddr), .IN_stData(IN_stData),
        .IN_stMask(IN_stMask), .OUT_stDisable(OUT_stDisable),
        .IN_ldValid(IN_ldValid), .IN_ldAddr(IN_ldAddr), .OUT_ldGrant(OUT_ldGrant),
        .IN_IO_busy(IN_IO_busy),
        .OUT_memValid(OUT_memValid), .OUT_memWe(OUT_memWe), .OUT_memAddr(OUT_memAddr),
        .OUT_memData(OUT_memData), .OUT_memMask(OUT_memMask), .IN_memReady(IN_memReady),
        .OUT_empty(OUT_empty), .OUT_overflow(OUT_overflow)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } st_t;

    st_t exp_st[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cb(input string name, input logic act, input logic req);
        check(name, {31'b0, act}, {31'b0, req});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; an accepted store is recorded in the scoreboard.
    task automatic drive(input logic stv, input logic [31:0] sa, input logic ldv,
                         input logic [31:0] la, input logic busy, input logic rdy,
                         input logic accept);
        st_t e;
        e.a = sa;
        e.d = $urandom;
        e.m = 4'($urandom_range(1, 15));
        IN_stValid  = stv;
        IN_stAddr   = sa;
        IN_stData   = e.d;
        IN_stMask   = e.m;
        IN_ldValid  = ldv;
        IN_ldAddr   = la;
        IN_IO_busy  = busy;
        IN_memReady = rdy;
        if (stv && accept) exp_st.push_back(e);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b0);
        step();
        step();
        exp_st.delete();
        rst = 1'b0;
        idle(1'b0);
    endtask

    // Monitor: every transfer is compared against the scoreboard or the driven load.
    initial begin : monitor
        logic        pend_st, last_io, is_io;
        logic [31:0] pend_addr;
        st_t         e;
        pend_st = 1'b0;
        last_io = 1'b0;
        pend_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_st = 1'b0;
                last_io = 1'b0;
            end else begin
                if (pend_st) begin
                    cb("hold_store_we", OUT_memValid && OUT_memWe, 1'b1);
                    check("hold_store_addr", OUT_memAddr, pend_addr);
                end
                pend_st = 1'b0;
                if (OUT_memValid && IN_memReady) begin
                    if (OUT_memWe) begin
                        is_io = (OUT_memAddr[31:24] == 8'hFF);
                        cb("store_expected", exp_st.size() > 0, 1'b1);
                        if (exp_st.size() > 0) begin
                            e = exp_st.pop_front();
                            check("st_addr", OUT_memAddr, e.a);
                            check("st_data", OUT_memData, e.d);
                            check("st_mask", {28'b0, OUT_memMask}, {28'b0, e.m});
                        end
                        if (is_io) cb("io_guard", last_io, 1'b0);
                        last_io = is_io;
                    end else begin
                        check("ld_addr", OUT_memAddr, IN_ldAddr);
                        check("ld_mask", {28'b0, OUT_memMask}, 32'hF);
                        last_io = 1'b0;
                    end
                end else begin
                    last_io = 1'b0;
                    if (OUT_memValid && OUT_memWe) begin
                        pend_st = 1'b1;
                        pend_addr = OUT_memAddr;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic        prev_dis, stv;
        logic [31:0] r, sa, la;
        int          n;

        do_reset();
        cb("rst_empty", OUT_empty, 1'b1);
        cb("rst_stdisable", OUT_stDisable, 1'b0);
        cb("rst_memvalid", OUT_memValid, 1'b0);
        cb("rst_ldgrant", OUT_ldGrant, 1'b0);
        cb("rst_overflow", OUT_overflow, 1'b0);

        // Three stores, no loads: each appears the cycle after its push.
        step(); drive(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cb("t1_c0_idle", OUT_memValid, 1'b0);
        step(); drive(1'b1, 32'h0000_0104, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cb("t1_c1_store", OUT_memValid && OUT_memWe, 1'b1);
        step(); drive(1'b1, 32'h0000_0108, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cb("t1_c2_store", OUT_memValid && OUT_memWe, 1'b1);
        step(); idle(1'b1);
        cb("t1_c3_store", OUT_memValid && OUT_memWe, 1'b1);
        step(); idle(1'b1);
        cb("t1_empty", OUT_empty, 1'b1);
        cb("t1_idle", OUT_memValid, 1'b0);

        // Fill with the memory stalled; the fifth store is dropped.
        for (int i = 0; i < 5; i++) begin
            step();
            drive(1'b1, 32'h0000_0200 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0, i < 4);
            cb("t2_stdisable", OUT_stDisable, i >= 3);
            cb("t2_overflow", OUT_overflow, 1'b0);
        end
        step(); idle(1'b1);
        cb("t2_overflow_set", OUT_overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cb("t2_not_empty", OUT_empty, 1'b0);
            step(); idle(1'b1);
        end
        cb("t2_drained", OUT_empty, 1'b1);
        cb("t2_overflow_sticky", OUT_overflow, 1'b1);

        // Reset with a stalled store buffered discards it and clears overflow.
        step(); drive(1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(); idle(1'b0);
        do_reset();
        cb("t2_rst_overflow", OUT_overflow, 1'b0);
        cb("t2_rst_empty", OUT_empty, 1'b1);
        cb("t2_rst_memvalid", OUT_memValid, 1'b0);

        // Starvation: three loads win, then the store is forced; twice to see starve cleared.
        for (int k = 0; k < 2; k++) begin
            step(); drive(1'b1, 32'h0000_0400 + 32'(k * 4), k == 1, 32'h2000_0000, 1'b0, 1'b1, 1'b1);
            if (k == 1) cb("t3_ld_after_store", OUT_ldGrant, 1'b1);
            for (int i = 0; i < 4; i++) begin
                step(); drive(1'b0, 32'h0, 1'b1, 32'h2000_0010 + 32'(i * 4), 1'b0, 1'b1, 1'b1);
                cb("t3_ldgrant", OUT_ldGrant, i < 3);
                cb("t3_store_forced", OUT_memWe, i == 3);
            end
        end
        step(); idle(1'b1);
        cb("t3_empty", OUT_empty, 1'b1);

        // MMIO head held off by IO-busy while loads keep flowing.
        step(); drive(1'b1, 32'hFF00_0010, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(); drive(1'b0, 32'h0, i > 0, 32'h2000_0100 + 32'(i * 4), 1'b1, 1'b1, 1'b1);
            if (i == 0) cb("t4_no_store", OUT_memValid, 1'b0);
            else begin
                cb("t4_ld_granted", OUT_ldGrant, 1'b1);
                cb("t4_no_store_we", OUT_memWe, 1'b0);
            end
        end
        step(); idle(1'b1);
        cb("t4_release_cycle", OUT_memValid, 1'b0);
        step(); idle(1'b1);
        cb("t4_io_issue", OUT_memValid && OUT_memWe, 1'b1);

        // Back-to-back MMIO stores need a guard cycle; a non-IO store may use it.
        step(); idle(1'b1);
        step(); drive(1'b1, 32'hFF00_0020, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(); drive(1'b1, 32'hFF00_0024, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cb("t5_io1_issue", OUT_memValid && OUT_memWe, 1'b1);
        step(); drive(1'b1, 32'h1000_0040, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cb("t5_guard_block", OUT_memValid, 1'b0);
        step(); idle(1'b1);
        cb("t5_io2_issue", OUT_memValid && OUT_memWe, 1'b1);
        step(); idle(1'b1);
        cb("t5_guard_nonio", OUT_memValid && OUT_memWe, 1'b1);
        step(); idle(1'b1);
        cb("t5_empty", OUT_empty, 1'b1);

        // Push and pop together at count 2 while the tail wraps 3 -> 0.
        do_reset();
        step(); drive(1'b1, 32'h0000_0500, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(); drive(1'b1, 32'h0000_0504, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(); drive(1'b1, 32'h0000_0508 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            cb("t6_count2_nodis", OUT_stDisable, 1'b0);
            cb("t6_count2_nonempty", OUT_empty, 1'b0);
        end
        step(); idle(1'b1);
        cb("t6_last2_a", OUT_empty, 1'b0);
        step(); idle(1'b1);
        cb("t6_last2_b", OUT_empty, 1'b0);
        step(); idle(1'b1);
        cb("t6_drained", OUT_empty, 1'b1);

        // Random traffic with a store queue that honours the disable with one cycle of slack.
        prev_dis = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            step();
            r   = $urandom;
            stv = !prev_dis && (r[1:0] == 2'b00 || r[1:0] == 2'b01 && r[2]);
            sa  = (r[4:3] == 2'b00) ? {24'hFF0000, r[12:7], 2'b00} : {8'h10, r[27:7], 3'b000};
            la  = {16'h2000, r[29:16], 2'b00};
            drive(stv, sa, r[30], la, r[31] && r[5], r[6] || r[13], 1'b1);
            prev_dis = OUT_stDisable;
        end
        n = 0;
        step(); idle(1'b1);
        while ((exp_st.size() != 0 || !OUT_empty) && n < 60) begin
            step(); idle(1'b1);
            n++;
        end
        check("rand_scoreboard_left", 32'(exp_st.size()), 32'd0);
        cb("rand_empty", OUT_empty, 1'b1);
        cb("rand_no_overflow", OUT_overflow, 1'b0);

        step(); idle(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
